// File: rtl/vit_sched_ctrl.sv
// Viterbi datapath scheduling controller: sequences the CE/S/ACS/M/T unit enables.
// Optional frame flush (FLUSH state, o_done pulse) is built only when CTRL_FLUSH_EN is defined.
module vit_sched_ctrl #(
    parameter int PIPE_DEPTH = 2,
    parameter int TB_DEPTH   = 8,
    parameter int CNT_W      = $clog2(((PIPE_DEPTH > TB_DEPTH) ? PIPE_DEPTH : TB_DEPTH) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             i_sync,
    input  logic             i_flush,
    output logic             o_en_ce,
    output logic             o_en_s,
    output logic             o_en_acs,
    output logic             o_en_m,
    output logic             o_en_t,
    output logic             o_done,
    output logic             o_busy,
    output logic [2:0]       p_state,
    output logic [CNT_W-1:0] p_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_PRIME   = 3'd2,
        S_RUN     = 3'd3,
        S_MEMFILL = 3'd4,
        S_TRACE   = 3'd5,
        S_FLUSH   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] PIPE_LAST = CNT_W'(PIPE_DEPTH - 1);
    localparam logic [CNT_W-1:0] TB_LAST   = CNT_W'(TB_DEPTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_inc;
    logic             w_done_set;

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (en) begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_inc    = 1'b0;
        w_done_set   = 1'b0;
        o_en_ce      = 1'b0;
        o_en_s       = 1'b0;
        o_en_acs     = 1'b0;
        o_en_m       = 1'b0;
        o_en_t       = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_FILL;
            S_FILL: begin
                o_en_ce = 1'b1;
                o_en_s  = 1'b1;
                if (r_cnt == PIPE_LAST) w_next_state = S_PRIME;
                else                    w_cnt_inc    = 1'b1;
            end
            S_PRIME: begin
                o_en_ce      = 1'b1;
                o_en_s       = 1'b1;
                o_en_acs     = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                o_en_ce  = 1'b1;
                o_en_s   = 1'b1;
                o_en_acs = 1'b1;
                o_en_m   = 1'b1;
                if (i_sync) w_next_state = S_MEMFILL;
            end
            S_MEMFILL: begin
                o_en_ce = 1'b1;
                o_en_s  = 1'b1;
                o_en_m  = 1'b1;
                if (r_cnt == TB_LAST) w_next_state = S_TRACE;
                else                  w_cnt_inc    = 1'b1;
            end
            S_TRACE: begin
                o_en_ce = 1'b1;
                o_en_s  = 1'b1;
                o_en_m  = 1'b1;
                o_en_t  = 1'b1;
`ifdef CTRL_FLUSH_EN
                if (i_flush) w_next_state = S_FLUSH;
`endif
            end
`ifdef CTRL_FLUSH_EN
            S_FLUSH: begin
                o_en_s = 1'b1;
                o_en_m = 1'b1;
                o_en_t = 1'b1;
                if (r_cnt == TB_LAST) begin
                    w_next_state = S_IDLE;
                    w_done_set   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // Counter restarts from zero whenever the state changes.
    assign w_cnt_next = (w_next_state != r_state) ? '0 :
                        (w_cnt_inc ? r_cnt + CNT_W'(1) : r_cnt);

`ifdef CTRL_FLUSH_EN
    logic r_done;

    // Done is armed only on an enabled FLUSH->IDLE edge and drops on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_done <= 1'b0;
        else      r_done <= en & w_done_set;
    end

    assign o_done = r_done;
`else
    logic w_unused_flush;
    logic w_unused_done;

    assign w_unused_flush = i_flush;
    assign w_unused_done  = w_done_set;
    assign o_done         = 1'b0;
`endif

    assign o_busy  = (r_state != S_IDLE);
    assign p_state = r_state;
    assign p_cnt   = r_cnt;

endmodule

// File: doc/vit_sched_ctrl.md
# vit_sched_ctrl

Parametrised scheduling controller for the Viterbi decoder datapath. It sequences the enables for codeword extraction (CE), state/branch-metric (S), add-compare-select (ACS), survivor memory (M) and traceback (T). Pipeline fill depth and traceback memory depth are compile-time parameters. An optional frame-flush mode drains traceback and returns to idle. It sits at the decoder top level beside the datapath units and drives their enable inputs directly.

## Interface
- PIPE_DEPTH, 2: cycles spent in FILL before ACS starts; legal range ≥1
- TB_DEPTH, 8: survivor-memory fill cycles before traceback, also flush length; legal range ≥2
- CNT_W, $clog2(max(PIPE_DEPTH,TB_DEPTH)+1): derived internal counter width; not overridden
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  global advance; when 0, state, counter and o_done hold their values
- i_sync  input  1  metric-normalisation/sync indication from the ACS unit; sampled only in RUN
- i_flush  input  1  end-of-frame request; sampled only in TRACE, and only when CTRL_FLUSH_EN is defined
- o_en_ce, o_en_s, o_en_acs, o_en_m, o_en_t  output  1 each  datapath unit enables
- o_done  output  1  one-cycle pulse on flush completion
- o_busy  output  1  high in every state except IDLE
- p_state  output  3  current state code (debug probe)
- p_cnt  output  CNT_W  current counter value (debug probe)

## Operation
- States and codes: IDLE=0, FILL=1, PRIME=2, RUN=3, MEMFILL=4, TRACE=5, FLUSH=6. Code 7 is illegal and forces IDLE with all enables 0.
- Enables are decoded combinationally from the state and listed as ce/s/acs/m/t:
  - IDLE 0/0/0/0/0
  - FILL 1/1/0/0/0
  - PRIME 1/1/1/0/0
  - RUN 1/1/1/1/0
  - MEMFILL 1/1/0/1/0
  - TRACE 1/1/0/1/1
  - FLUSH 0/1/0/1/1
- Transitions occur only on edges where en=1:
  - IDLE→FILL unconditionally.
  - FILL→PRIME when cnt==PIPE_DEPTH-1, otherwise cnt++.
  - PRIME→RUN.
  - RUN→MEMFILL when i_sync=1; otherwise stay in RUN.
  - MEMFILL→TRACE when cnt==TB_DEPTH-1, otherwise cnt++.
  - TRACE stays in TRACE, except TRACE→FLUSH when i_flush=1 and the macro is defined.
  - FLUSH→IDLE when cnt==TB_DEPTH-1, otherwise cnt++.
- The counter clears to 0 on every state change, so each counted state starts from 0.
- o_done is a registered signal: set on the FLUSH→IDLE edge and cleared on the next edge regardless of en.
- i_sync outside RUN is ignored. i_flush outside TRACE is ignored and is not latched.

## Timing
- Reset (asynchronous, rst=0): state=IDLE, cnt=0, o_done=0. All enables, o_busy and the probes read 0 immediately, without waiting for a clock edge.
- With en held at 1 from the first edge after reset release, time spent in each state:
  - IDLE 1 cycle.
  - FILL exactly PIPE_DEPTH cycles.
  - PRIME 1 cycle.
  - MEMFILL exactly TB_DEPTH cycles.
  - FLUSH exactly TB_DEPTH cycles.
- First o_en_acs: edge 1+PIPE_DEPTH after reset release. First o_en_m: one cycle later.
- i_sync seen high at a RUN edge: MEMFILL begins the following cycle, o_en_acs drops in that same cycle, and o_en_t rises TB_DEPTH cycles later.
- en=0 for N cycles: everything freezes, enables keep their current values, and total sequence length grows by exactly N.
- en=0 together with i_sync=1 or i_flush=1: the request is lost; it must be presented again on an enabled cycle.
- Reset asserted mid-sequence (any state): abort to IDLE immediately. No o_done is produced.

## Configuration
- CTRL_FLUSH_EN defined:
  - The FLUSH state and the TRACE→FLUSH transition exist.
  - o_done is generated as described above.
- CTRL_FLUSH_EN undefined:
  - i_flush is present but unused, and TRACE is terminal.
  - o_done is tied to 0.
  - Code 6 is treated as illegal and forces IDLE.

## Test plan
- Defaults, rst released, en=1, i_sync=0: edge 0 IDLE; edges 1–2 FILL with ce=s=1; edge 3 PRIME with acs=1; edge 4 onward RUN with m=1; stays in RUN for 20 cycles.
- From RUN, pulse i_sync=1 for 1 cycle: 8 cycles of MEMFILL (acs=0, m=1, p_cnt 0→7), then TRACE with t=1, held for 50 cycles.
- en=0 for 5 cycles while MEMFILL has p_cnt=3: outputs and p_cnt hold; after en returns, 5 more MEMFILL cycles follow before TRACE.
- CTRL_FLUSH_EN defined, i_flush=1 in TRACE: 8 FLUSH cycles (ce=0, s=m=t=1); then IDLE with o_done=1 for exactly 1 cycle; FILL follows on the next edge.
- rst=0 asserted between edges during TRACE: all enables, o_busy and p_state go to 0 asynchronously; after release the full sequence replays.
- PIPE_DEPTH=4, TB_DEPTH=16: FILL lasts 4 cycles, MEMFILL 16 and FLUSH 16; CNT_W=5.
